// File: rtl/mdu_ctrl.sv
// ============================================================================
//  Module      : mdu_ctrl
//  Description : HI/LO multiply-divide unit controller for a 5-stage pipeline.
//                mult/multu/div/divu latch their operands and hold the unit
//                busy for a fixed number of cycles. The HI/LO result is
//                written on the final busy edge. mthi/mtlo write HI/LO
//                directly in one cycle. A combinational stall freezes F/D
//                while a D-stage HI/LO user waits on the unit.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                start, op       - E-stage MDU request and operation code
//                opA, opB        - forwarded rs / rt operands
//                dUsesMdu        - D-stage instruction touches HI/LO
//                busy, stall     - unit busy, pipeline stall request
//                hi, lo          - HI / LO registers
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic        dUsesMdu,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    // Declaration initialisers give the reset state at power-up.
    logic [0:0]         r_state = c_IDLE;
    logic [c_CNT_W-1:0] r_cnt   = '0;
    logic [2:0]         r_op    = '0;
    logic [31:0]        r_opA   = '0;
    logic [31:0]        r_opB   = '0;
    logic [31:0]        r_hi    = '0;
    logic [31:0]        r_lo    = '0;

    logic               w_startLong;
    logic signed [63:0] w_extA;
    logic signed [63:0] w_extB;
    logic signed [63:0] w_prodS;
    logic [63:0]        w_prodU;
    logic [31:0]        w_divisorU;
    logic [31:0]        w_absA;
    logic [31:0]        w_absB;
    logic [31:0]        w_qMag;
    logic [31:0]        w_rMag;
    logic [31:0]        w_resHi;
    logic [31:0]        w_resLo;
    logic               w_resValid;

    assign w_startLong = start && (op >= c_OP_MULT) && (op <= c_OP_DIVU);

    assign busy  = (r_state == c_BUSY);
    assign stall = dUsesMdu & (busy | w_startLong);
    assign hi    = r_hi;
    assign lo    = r_lo;

    // Result datapath works only on latched operands, so the forwarded
    // operand buses are free to change while the unit is busy.
    always_comb begin
        w_extA     = {{32{r_opA[31]}}, r_opA};
        w_extB     = {{32{r_opB[31]}}, r_opB};
        w_prodS    = w_extA * w_extB;
        w_prodU    = {32'd0, r_opA} * {32'd0, r_opB};
        // A zero divisor is replaced by 1 purely to keep the divider defined;
        // the write is suppressed via w_resValid in that case.
        w_divisorU = (r_opB == 32'd0) ? 32'd1 : r_opB;
        // Signed division is done on magnitudes so that 0x80000000 / -1
        // naturally wraps back to 0x80000000 instead of overflowing.
        w_absA     = r_opA[31] ? (32'd0 - r_opA) : r_opA;
        w_absB     = r_opB[31] ? (32'd0 - r_opB) : w_divisorU;
        w_qMag     = '0;
        w_rMag     = '0;
        w_resHi    = r_hi;
        w_resLo    = r_lo;
        w_resValid = 1'b1;
        case (r_op)
            c_OP_MULT: begin
                w_resHi = w_prodS[63:32];
                w_resLo = w_prodS[31:0];
            end
            c_OP_MULTU: begin
                w_resHi = w_prodU[63:32];
                w_resLo = w_prodU[31:0];
            end
            c_OP_DIV: begin
                w_resValid = (r_opB != 32'd0);
                w_qMag     = w_absA / w_absB;
                w_rMag     = w_absA % w_absB;
                // Quotient truncates toward zero; remainder follows dividend.
                w_resLo    = (r_opA[31] ^ r_opB[31]) ? (32'd0 - w_qMag) : w_qMag;
                w_resHi    = r_opA[31] ? (32'd0 - w_rMag) : w_rMag;
            end
            c_OP_DIVU: begin
                w_resValid = (r_opB != 32'd0);
                w_resLo    = r_opA / w_divisorU;
                w_resHi    = r_opA % w_divisorU;
            end
            default: begin
                w_resValid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_opA   <= '0;
            r_opB   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        case (op)
                            c_OP_MULT, c_OP_MULTU: begin
                                r_state <= c_BUSY;
                                r_cnt   <= c_MULT_LOAD;
                                r_op    <= op;
                                r_opA   <= opA;
                                r_opB   <= opB;
                            end
                            c_OP_DIV, c_OP_DIVU: begin
                                r_state <= c_BUSY;
                                r_cnt   <= c_DIV_LOAD;
                                r_op    <= op;
                                r_opA   <= opA;
                                r_opB   <= opB;
                            end
                            c_OP_MTHI: r_hi <= opA;
                            c_OP_MTLO: r_lo <= opA;
                            default: ;
                        endcase
                    end
                end
                c_BUSY: begin
                    // New requests are ignored here; only the countdown runs.
                    if (r_cnt <= c_CNT_ONE) begin
                        r_cnt   <= '0;
                        r_state <= c_IDLE;
                        if (w_resValid) begin
                            r_hi <= w_resHi;
                            r_lo <= w_resLo;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
// ============================================================================
//  Module      : tb_mdu_ctrl
//  Description : Self-checking bench for mdu_ctrl. Expected HI/LO results
//                are pushed to a scoreboard queue on issue and popped when
//                busy falls.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        dUsesMdu;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;
    logic [63:0] sbq[$];

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .opA      (opA),
        .opB      (opB),
        .dUsesMdu (dUsesMdu),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: 64-bit arithmetic, returns {hi, lo}.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] h,
                                          input logic [31:0] l);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            3'd1: return 64'(sa * sb);
            3'd2: return ua * ub;
            3'd3: begin
                if (b == 32'd0) return {h, l};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 32'd0) return {h, l};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return {h, l};
        endcase
    endfunction

    // Issue one multi-cycle op and follow it to completion.
    task automatic runLong(input string tag, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic d, input int expN,
                           input bit poke);
        int cnt;
        logic [63:0] exp;
        @(posedge clk); #1;
        start = 1'b1; op = o; opA = a; opB = b; dUsesMdu = d;
        sbq.push_back(model(o, a, b, mHi, mLo));
        @(negedge clk);
        chk({tag, ".busyAtIssue"}, busy, 1'b0);
        chk({tag, ".stallAtIssue"}, stall, d);
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        opA = $urandom; opB = $urandom;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
            chk({tag, ".stallBusy"}, stall, d);
            chk({tag, ".hiHold"}, hi, mHi);
            chk({tag, ".loHold"}, lo, mLo);
            if (poke && cnt == 2) begin
                start = 1'b1; op = 3'd1; opA = 32'd9; opB = 32'd9;
            end
            if (poke && cnt == 3) begin
                start = 1'b0; op = 3'd0;
            end
            if (cnt > 60) begin
                chk({tag, ".busyTimeout"}, busy, 1'b0);
                break;
            end
        end
        chk({tag, ".busyCycles"}, cnt, expN);
        chk({tag, ".stallAfter"}, stall, 1'b0);
        if (sbq.size() == 0) begin
            chk({tag, ".sbEmpty"}, 32'd0, 32'd1);
        end else begin
            exp = sbq.pop_front();
            chk({tag, ".hi"}, hi, exp[63:32]);
            chk({tag, ".lo"}, lo, exp[31:0]);
            mHi = exp[63:32];
            mLo = exp[31:0];
        end
        @(posedge clk); #1;
        dUsesMdu = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; opA = '0; opB = '0; dUsesMdu = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Stall while in reset depends only on the incoming request.
        start = 1'b1; op = 3'd1; dUsesMdu = 1'b1;
        @(negedge clk);
        chk("rst.busy", busy, 1'b0);
        chk("rst.hi", hi, 32'd0);
        chk("rst.lo", lo, 32'd0);
        chk("rst.stall", stall, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0; op = 3'd0; dUsesMdu = 1'b0;
        @(negedge clk);
        chk("rst.busyHeld", busy, 1'b0);

        runLong("mult",  3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 5, 1'b0);
        runLong("multu", 3'd2, 32'hFFFFFFFE, 32'd3, 1'b0, 5, 1'b0);
        runLong("div",   3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 10, 1'b0);
        runLong("div0",  3'd3, 32'd7, 32'd0, 1'b0, 10, 1'b0);
        runLong("divuOv", 3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10, 1'b0);
        runLong("divOv", 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10, 1'b0);
        runLong("multStall", 3'd1, 32'h00012345, 32'hFFF54321, 1'b1, 5, 1'b1);
        runLong("divu", 3'd4, 32'hDEADBEEF, 32'h00001234, 1'b0, 10, 1'b0);
        runLong("divNeg", 3'd3, 32'd100, 32'hFFFFFFF9, 1'b0, 10, 1'b0);

        // no-op codes leave everything untouched
        @(posedge clk); #1;
        start = 1'b1; op = 3'd7; opA = 32'hAAAA5555;
        @(posedge clk); #1;
        op = 3'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("nop.busy", busy, 1'b0);
        chk("nop.hi", hi, mHi);
        chk("nop.lo", lo, mLo);

        // reset in the middle of a divide discards the result
        @(posedge clk); #1;
        start = 1'b1; op = 3'd4; opA = 32'd1000; opB = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midRst.busy", busy, 1'b0);
        chk("midRst.hi", hi, 32'd0);
        chk("midRst.lo", lo, 32'd0);
        mHi = '0; mLo = '0;
        repeat (12) @(negedge clk);
        chk("midRst.busyLater", busy, 1'b0);
        chk("midRst.hiLater", hi, 32'd0);
        chk("midRst.loLater", lo, 32'd0);

        // mthi / mtlo complete in one edge
        @(posedge clk); #1;
        start = 1'b1; op = 3'd5; opA = 32'h12345678;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0; opA = '0;
        @(negedge clk);
        chk("mthi.hi", hi, 32'h12345678);
        chk("mthi.lo", lo, 32'd0);
        chk("mthi.busy", busy, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; op = 3'd6; opA = 32'hCAFEF00D;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        @(negedge clk);
        chk("mtlo.lo", lo, 32'hCAFEF00D);
        chk("mtlo.hi", hi, 32'h12345678);
        chk("mtlo.busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, busy cycles for mult/multu.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 The block SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  E-stage instruction is an MDU operation this cycle.
REQ-006 The block SHALL have port op  input  3  operation: 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 0 and 7 are no-op.
REQ-007 The block SHALL have port opA  input  32  rs operand (forwarded value).
REQ-008 The block SHALL have port opB  input  32  rt operand (forwarded value).
REQ-009 The block SHALL have port dUsesMdu  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-010 The block SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-011 The block SHALL have port stall  output  1  freeze F/D pipeline registers and insert bubble into E register.
REQ-012 The block SHALL have port hi  output  32  HI register.
REQ-013 The block SHALL have port lo  output  32  LO register.

Function
REQ-014 The block SHALL have two states, IDLE and BUSY; busy SHALL be 1 exactly in BUSY.
REQ-015 In IDLE, start=1 with op 1-4 sampled at edge t SHALL latch opA/opB and op, load a down-counter with MULT_CYCLES (op 1,2) or DIV_CYCLES (op 3,4), and enter BUSY.
REQ-016 busy SHALL be 1 for exactly N cycles after edge t (N = loaded count); at the edge where the counter goes 1->0 the result SHALL be written to hi/lo and the state SHALL return to IDLE.
REQ-017 hi/lo SHALL hold their prior values throughout BUSY and SHALL show the new result from the first IDLE cycle.
REQ-018 mult: {hi,lo} SHALL be the signed 64-bit product; multu: the unsigned 64-bit product.
REQ-019 div: lo SHALL be the signed quotient truncated toward zero and hi the remainder with the dividend's sign; divu: unsigned quotient/remainder.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000.
REQ-021 Division by zero SHALL still occupy BUSY for DIV_CYCLES and SHALL leave hi and lo unchanged.
REQ-022 In IDLE, start=1 with op 5 (mthi) or op 6 (mtlo) SHALL write opA to hi or lo at that edge without entering BUSY.
REQ-023 start=1 while in BUSY SHALL be ignored (no latch, no hi/lo write, counter unaffected).
REQ-024 start=1 with op 0 or 7 SHALL have no effect.
REQ-025 stall SHALL be combinational: stall = dUsesMdu & (busy | (start & op in 1-4)); otherwise 0.
REQ-026 stall SHALL deassert in the same cycle busy falls, so a stalled mflo reads the new lo on its first unstalled cycle.
REQ-027 Operand values changing on opA/opB during BUSY SHALL not affect the result.

Reset
REQ-028 reset=1 at a rising edge SHALL force IDLE, counter=0, busy=0, hi=0, lo=0, regardless of start or current state.
REQ-029 reset asserted mid-BUSY SHALL discard the pending result; no hi/lo write SHALL occur after reset.
REQ-030 With reset=1, stall SHALL equal dUsesMdu & start & (op in 1-4) since busy=0; the pipeline registers clear independently.
REQ-031 Before the first reset, the block SHALL power up in the reset state (IDLE, all zero).

Verification
REQ-032 mult opA=0xFFFFFFFE (-2), opB=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; multu same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-033 div opA=0xFFFFFFF9 (-7), opB=2 -> busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; div opA=7, opB=0 -> hi/lo unchanged after 10 cycles.
REQ-034 divu 0x80000000/0xFFFFFFFF -> lo=0, hi=0x80000000; div same operands -> lo=0x80000000, hi=0.
REQ-035 mult issued, dUsesMdu=1 (mflo) held -> stall=1 on start cycle and all 5 busy cycles, 0 on the next cycle with lo holding the product; second start during BUSY ignored.
REQ-036 reset pulsed at busy cycle 3 of div -> busy=0, hi=lo=0 next cycle, no later write; mthi opA=0x12345678 in IDLE -> hi=0x12345678 next cycle, busy stays 0.
